mod_memreader: RTL and testbench

//  Read-side counterpart of the boot-time ROM->RAM loader: fetches a burst of 32-bit words

---
 rtl/mod_memreader.sv | 122 ++++++++++++
 tb/tb_mod_memreader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_memreader.sv
// mod_memreader: fetches a burst of RAM words and streams them to a consumer over VALID/READY.
// Rev 1.0 - initial release.
`default_nettype none

module mod_memreader #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [0:DATA_W-1] dout_o,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [0:DATA_W-1] ram_data_i,
  output logic              ram_ce_n_o,
  output logic              ram_oe_n_o,
  output logic              ram_we_n_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_FINISH  = 3'd4
  } state_e;

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic [0:DATA_W-1]   dout_q;
  logic                valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    rem_q;
  logic                ce_n_q;
  logic                oe_n_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (len_i != '0) begin
              addr_q  <= base_addr_i;
              rem_q   <= len_i;
              ce_n_q  <= 1'b0;
              oe_n_q  <= 1'b0;
              state_q <= S_SETUP;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end
          end
        end
        S_SETUP: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // RAM is released as soon as the word is latched so it idles during consumer stalls
          dout_q  <= ram_data_i;
          valid_q <= 1'b1;
          rem_q   <= rem_q - LEN_W'(1);
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (dout_ready_i) begin
            valid_q <= 1'b0;
            if (rem_q == '0) begin
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              addr_q  <= addr_q + ADDR_W'(1);
              ce_n_q  <= 1'b0;
              oe_n_q  <= 1'b0;
              state_q <= S_SETUP;
            end
          end
        end
        S_FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign ram_addr_o   = addr_q;
  assign ram_ce_n_o   = ce_n_q;
  assign ram_oe_n_o   = oe_n_q;
  assign ram_we_n_o   = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_mod_memreader.sv
// tb_mod_memreader: vector table, hand-written corner sequences and random bursts for mod_memreader.
`default_nettype none

module tb_mod_memreader;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int MEMSZ = 32768;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [LW-1:0] len;
  logic          busy, done, dv, rdy, ce_n, oe_n, we_n;
  logic [0:DW-1] dout, rdata;
  logic [AW-1:0] raddr;

  logic [31:0] mem [0:MEMSZ-1];
  assign rdata = mem[raddr];

  mod_memreader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base), .len_i(len),
    .busy_o(busy), .done_o(done), .dout_o(dout), .dout_valid_o(dv), .dout_ready_i(rdy),
    .ram_addr_o(raddr), .ram_data_i(rdata), .ram_ce_n_o(ce_n), .ram_oe_n_o(oe_n),
    .ram_we_n_o(we_n)
  );

  logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  logic [31:0] H [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    int            stall_pct;
    int            fixed_stall;
    int            restart_at;
    logic [31:0]   first_w;
    logic [31:0]   last_w;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] got_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_done"}, done, 1'b0);
    chk({nm, "_valid"}, dv, 1'b0);
    chk({nm, "_dout"}, dout, 32'h0);
    chk({nm, "_addr"}, raddr, 32'h0);
    chk({nm, "_ce_n"}, ce_n, 1'b1);
    chk({nm, "_oe_n"}, oe_n, 1'b1);
    chk({nm, "_we_n"}, we_n, 1'b1);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the DONE cycle.
  task automatic run_burst(input logic [AW-1:0] b, input logic [LW-1:0] n, input int stall_pct,
                           input int fixed_stall, input int restart_at);
    logic [31:0] expq[$];
    logic [31:0] prev_dout;
    int cyc, words, hs_cyc, stalls, budget;
    bit prev_stall, prev_valid, seen_done;
    got_q.delete();
    for (int i = 0; i < int'(n); i++) expq.push_back(mem[(int'(b) + i) % MEMSZ]);
    start = 1'b1; base = b; len = n;
    @(negedge clk);
    start = 1'b0; base = AW'($urandom); len = LW'($urandom);
    cyc = 1; words = 0; hs_cyc = 0; stalls = 0; budget = int'(n) * 25 + 50;
    prev_stall = 0; prev_valid = 0; seen_done = 0; prev_dout = '0;
    while (!seen_done && cyc < budget) begin
      start = 1'b0;
      if (cyc == restart_at) begin start = 1'b1; base = '0; len = 16'd1; end
      chk("we_n_high", we_n, 1'b1);
      chk("ce_eq_oe", ce_n, oe_n);
      if (!ce_n) begin
        chk("ram_addr", raddr, 32'((int'(b) + words) % MEMSZ));
        chk("valid_while_ce", dv, 1'b0);
      end
      if (prev_stall) begin
        chk("hold_valid", dv, 1'b1);
        chk("hold_dout", dout, prev_dout);
      end
      if (done) begin
        chk("done_words", words, 32'(n));
        chk("done_latency", cyc, hs_cyc + 1);
        chk("busy_at_done", busy, 1'b1);
        chk("ce_n_at_done", ce_n, 1'b1);
        seen_done = 1;
      end else begin
        chk("busy_in_burst", busy, 1'b1);
        if (dv && !prev_valid) chk("valid_latency", cyc - hs_cyc, 3);
      end
      if (dv) begin
        chk("ce_n_while_valid", ce_n, 1'b1);
        if (stalls < fixed_stall) begin
          rdy = 1'b0;
          stalls++;
        end else begin
          rdy = ($urandom_range(99) >= stall_pct);
        end
        if (rdy) begin
          chk("word", dout, (words < expq.size()) ? expq[words] : 32'hxxxxxxxx);
          got_q.push_back(dout);
          words++;
          hs_cyc = cyc;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_dout = dout;
        end
      end else begin
        rdy = 1'($urandom);
        prev_stall = 0;
      end
      prev_valid = dv;
      @(negedge clk);
      cyc++;
    end
    rdy = 1'b0;
    start = 1'b0;
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout base %h len %0d words %0d", b, n, words);
    end else begin
      chk("done_pulse", done, 1'b0);
      chk("busy_clear", busy, 1'b0);
    end
  endtask

  initial begin
    vec_t vecs [4];
    rst_n = 1'b1; start = 1'b0; base = '0; len = '0; rdy = 1'b0;
    for (int a = 0; a < MEMSZ; a++) mem[a] = 32'(a) * 32'h9e3779b1 ^ 32'h5a5a0000;
    for (int a = 0; a < 64; a++) mem[a] = K[a];
    for (int a = 0; a < 8; a++) mem[64 + a] = H[a];
    mem[15'h7ffe] = 32'hfeedface;
    mem[15'h7fff] = 32'hcafef00d;

    vecs[0] = '{base: 15'd0,      len: 16'd72, stall_pct: 0,  fixed_stall: 0, restart_at: 0,
                first_w: 32'h428a2f98, last_w: 32'h5be0cd19};
    vecs[1] = '{base: 15'd64,     len: 16'd1,  stall_pct: 0,  fixed_stall: 5, restart_at: 0,
                first_w: 32'h6a09e667, last_w: 32'h6a09e667};
    vecs[2] = '{base: 15'h7ffe,   len: 16'd4,  stall_pct: 0,  fixed_stall: 0, restart_at: 0,
                first_w: 32'hfeedface, last_w: 32'h71374491};
    vecs[3] = '{base: 15'd10,     len: 16'd3,  stall_pct: 40, fixed_stall: 1, restart_at: 4,
                first_w: 32'h243185be, last_w: 32'h72be5d74};

    #2 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_held");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_burst(vecs[i].base, vecs[i].len, vecs[i].stall_pct, vecs[i].fixed_stall, vecs[i].restart_at);
      chk("word_count", got_q.size(), 32'(vecs[i].len));
      if (got_q.size() == int'(vecs[i].len) && got_q.size() > 0) begin
        chk("first_word", got_q[0], vecs[i].first_w);
        chk("last_word", got_q[$], vecs[i].last_w);
        if (vecs[i].len == 16'd72) begin
          chk("word63", got_q[63], 32'hc67178f2);
          chk("word64", got_q[64], 32'h6a09e667);
        end
      end
      repeat (2) @(negedge clk);
    end

    // Zero-length burst: DONE without any RAM access.
    start = 1'b1; len = 16'd0; base = 15'd123;
    @(negedge clk);
    start = 1'b0;
    chk("len0_done", done, 1'b1);
    chk("len0_busy", busy, 1'b1);
    chk("len0_ce_n", ce_n, 1'b1);
    chk("len0_valid", dv, 1'b0);
    @(negedge clk);
    chk("len0_done_clear", done, 1'b0);
    chk("len0_busy_clear", busy, 1'b0);
    chk("len0_ce_n_after", ce_n, 1'b1);
    chk("len0_valid_after", dv, 1'b0);

    // START held through FINISH is ignored there, then accepted back in IDLE.
    @(negedge clk);
    start = 1'b1; len = 16'd0;
    @(negedge clk);
    chk("hold_start_done1", done, 1'b1);
    @(negedge clk);
    chk("finish_start_ignored_busy", busy, 1'b0);
    chk("finish_start_ignored_done", done, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("idle_start_accepted", done, 1'b1);
    @(negedge clk);
    chk("idle_start_done_clear", done, 1'b0);

    // Asynchronous reset in the middle of a burst.
    @(negedge clk);
    start = 1'b1; base = 15'd5; len = 16'd4; rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midburst_reset");
    @(negedge clk);
    rst_n = 1'b1;
    rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_reset", done, 1'b0);
      chk("idle_after_reset", busy, 1'b0);
    end
    run_burst(15'd20, 16'd2, 30, 0, 0);
    chk("post_reset_count", got_q.size(), 32'd2);

    // Random bursts against the memory model.
    repeat (10) begin
      logic [AW-1:0] rb;
      logic [LW-1:0] rn;
      rb = ($urandom_range(3) == 0) ? AW'(15'h7ffc + 15'($urandom_range(3))) : AW'($urandom);
      rn = LW'($urandom_range(1, 5));
      run_burst(rb, rn, 40, $urandom_range(2), 0);
      chk("rand_count", got_q.size(), 32'(rn));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
